lsu_dm_master: RTL and testbench

LSU_DM_MASTER -- requirements
Module: lsu_dm_master

---
 rtl/lsu_dm_master.sv | 147 ++++++++++++++
 tb/tb_lsu_dm_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dm_master.sv
// rtl/lsu_dm_master.sv - single-outstanding load/store master driving a synchronous-read data memory
// Half stores are read-modify-write; every output comes straight from a register.
module lsu_dm_master #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_half,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              we_DM,
   output logic [ADDR_W-1:0] addDM,
   output logic [DATA_W-1:0] dataDM,
   input  logic [DATA_W-1:0] outDM
);

   typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

   localparam logic [31:0] DEPTH_U = DEPTH;

   state_t              state_q;
   logic                rd_wait_q;
   logic                we_q;
   logic                half_q;
   logic                signed_q;
   logic [15:0]         wdata_lo_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic                resp_err_q;
   logic                we_dm_q;
   logic [ADDR_W-1:0]   add_dm_q;
   logic [DATA_W-1:0]   data_dm_q;

   logic                fault_d;
   logic [DATA_W-1:0]   ld_data_d;
   logic [DATA_W-1:0]   merge_data_d;

   assign fault_d      = 32'(req_addr) >= DEPTH_U;
   assign merge_data_d = {outDM[DATA_W-1:16], wdata_lo_q};

   always_comb begin
      ld_data_d = outDM;
      if (half_q) begin
         ld_data_d = {{(DATA_W-16){signed_q & outDM[15]}}, outDM[15:0]};
      end
   end

   // RD spends its first cycle letting datamem register the word; the response
   // register is armed one edge after RESP entry on the fault and WR paths.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_wait_q    <= 1'b0;
         we_q         <= 1'b0;
         half_q       <= 1'b0;
         signed_q     <= 1'b0;
         wdata_lo_q   <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         we_dm_q      <= 1'b0;
         add_dm_q     <= '0;
         data_dm_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  we_q        <= req_we;
                  half_q      <= req_half;
                  signed_q    <= req_signed;
                  wdata_lo_q  <= req_wdata[15:0];
                  resp_data_q <= '0;
                  resp_err_q  <= 1'b0;
                  if (fault_d) begin
                     resp_err_q <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     add_dm_q <= req_addr;
                     if (req_we && !req_half) begin
                        we_dm_q   <= 1'b1;
                        data_dm_q <= req_wdata;
                        state_q   <= WR;
                     end else begin
                        rd_wait_q <= 1'b1;
                        state_q   <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (rd_wait_q) begin
                  rd_wait_q <= 1'b0;
               end else if (we_q) begin
                  we_dm_q   <= 1'b1;
                  data_dm_q <= merge_data_d;
                  state_q   <= MERGE;
               end else begin
                  resp_data_q  <= ld_data_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end
            end
            MERGE: begin
               we_dm_q      <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            WR: begin
               we_dm_q <= 1'b0;
               state_q <= RESP;
            end
            RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign we_DM      = we_dm_q;
   assign addDM      = add_dm_q;
   assign dataDM     = data_dm_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb/tb_lsu_dm_master.sv - scoreboard bench for lsu_dm_master against a behavioural datamem
module tb_lsu_dm_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic        req_half = 1'b0;
   logic        req_signed = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        we_DM;
   logic [11:0] addDM;
   logic [31:0] dataDM;
   logic [31:0] outDM = '0;

   lsu_dm_master #(.DEPTH(32), .ADDR_W(12), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_half(req_half), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err), .we_DM(we_DM),
      .addDM(addDM), .dataDM(dataDM), .outDM(outDM)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:31];
   always @(posedge clk) begin
      if (we_DM) mem[addDM[4:0]] <= dataDM;
      else       outDM <= mem[addDM[4:0]];
   end

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          we;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [0:31];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          we_cnt = 0;
   int          we_base = 0;
   bit          in_resp = 0;
   int          first_cyc;
   logic [31:0] first_data;
   logic        first_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (we_DM === 1'b1) we_cnt++;
      if (resp_valid === 1'b1) begin
         chk("rdy_in_resp", {31'b0, req_ready}, 32'd0);
         if (!in_resp) begin
            in_resp    = 1;
            first_cyc  = cyc;
            first_data = resp_data;
            first_err  = resp_err;
         end else begin
            chk("hold_data", resp_data, first_data);
            chk("hold_err", {31'b0, resp_err}, {31'b0, first_err});
         end
         if (resp_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_resp", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", first_cyc - e.acc, e.lat);
               chk("resp_data", resp_data, e.data);
               chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
               chk("we_pulses", we_cnt - we_base, e.we);
            end
            we_base = we_cnt;
            in_resp = 0;
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input bit we, input bit half, input bit sgn, input int addr, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] w;
      bit          fault;
      wait_ready();
      fault  = addr >= 32;
      e.data = 32'd0;
      e.err  = fault;
      e.we   = (we && !fault) ? 1 : 0;
      e.lat  = fault ? 1 : (we && half) ? 3 : 2;
      if (!fault) begin
         w = ref_mem[addr];
         if (!we) e.data = !half ? w : sgn ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
         else     ref_mem[addr] = half ? {w[31:16], wd[15:0]} : wd;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_half   = half;
      req_signed = sgn;
      req_addr   = 12'(addr);
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.acc     = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("resp_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int t;
      for (int i = 0; i < 32; i++) begin
         mem[i]     = 32'h0;
         ref_mem[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_we", {31'b0, we_DM}, 32'd0);
      chk("rst_addDM", {20'b0, addDM}, 32'd0);
      chk("rst_dataDM", dataDM, 32'd0);
      rst = 1'b0;

      issue(1, 0, 0, 0, 32'h00001DFE);  wait_done();
      issue(0, 0, 0, 0, 32'h0);         wait_done();
      issue(1, 0, 0, 5, 32'hAAAA1111);  wait_done();
      issue(1, 1, 0, 5, 32'h0000F00D);  wait_done();
      issue(0, 0, 0, 5, 32'h0);         wait_done();
      issue(1, 0, 0, 3, 32'h00008001);  wait_done();
      issue(0, 1, 1, 3, 32'h0);         wait_done();
      issue(0, 1, 0, 3, 32'h0);         wait_done();
      issue(0, 0, 0, 32, 32'h0);        wait_done();
      issue(1, 0, 0, 32, 32'hDEADBEEF); wait_done();
      issue(1, 0, 0, 31, 32'h7FFF8000); wait_done();
      issue(0, 1, 1, 31, 32'h0);        wait_done();

      resp_ready = 1'b0;
      issue(0, 0, 0, 5, 32'h0);
      t = 0;
      while (resp_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("stall_timeout", 32'd0, 32'd1);
      repeat (4) @(negedge clk);
      resp_ready = 1'b1;
      wait_done();

      for (int i = 0; i < 16; i++) begin
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 35), $urandom);
         wait_done();
      end

      issue(1, 0, 0, 7, 32'hCAFE0000); wait_done();
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_half = 1'b1;
      req_addr = 12'd7; req_wdata = 32'h00001234;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("merge_we", {31'b0, we_DM}, 32'd1);
      chk("merge_data", dataDM, 32'hCAFE1234);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("mrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("mrst_resp_data", resp_data, 32'd0);
      chk("mrst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("mrst_we", {31'b0, we_DM}, 32'd0);
      chk("mrst_addDM", {20'b0, addDM}, 32'd0);
      chk("mrst_dataDM", dataDM, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("mrst_no_resp", {31'b0, resp_valid}, 32'd0);
      end
      we_base = we_cnt;
      in_resp = 0;
      ref_mem[7] = 32'hCAFE1234;
      issue(0, 0, 0, 7, 32'h0); wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1);
   end

endmodule
